// File: rtl/artemis_reset_pkg.sv
// Shared types and constants for the Artemis clock-tree reset sequencer.
//   state_e  : FSM state encoding, also the value seen on the state port
//   STATE_W  : width of the state code
//   FAIL_W   : width of the saturating failure counter
//   sat_inc  : saturating increment used for the failure counter
package artemis_reset_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned FAIL_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST      = 3'd0,
        ST_WAIT_LOCK    = 3'd1,
        ST_LOCK_STABLE  = 3'd2,
        ST_SYS_RST_HOLD = 3'd3,
        ST_RUN          = 3'd4
    } state_e;

    // Increment that holds at all-ones instead of wrapping.
    function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
        return (v == '1) ? v : v + FAIL_W'(1);
    endfunction

endpackage

// File: rtl/artemis_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   rst_n : async active-low reset, clears both flops to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles of latency
module artemis_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second gives it a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/artemis_reset_seq.sv
// Power-up and lock-supervision sequencer for the Artemis clock tree.
// Holds the PLL in reset, waits for lock, requires lock to stay stable,
// holds system reset a while longer, then raises ready. Lock timeouts and
// lock losses restart the PLL and are counted for debug.
//   clk        : free-running 100 MHz board clock
//   rst_n      : async active-low reset
//   pll_locked : PLL LOCKED, asynchronous to clk
//   sw_rst     : single-cycle request to restart the full sequence
//   pll_rst    : active-high PLL reset
//   sys_rst    : active-high system reset
//   ready      : high only in RUN
//   state      : current FSM state code
//   fail_count : timeouts plus lock losses, saturating
module artemis_reset_seq
    import artemis_reset_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 20000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned SYS_RST_CYCLES      = 256,
    parameter int unsigned CNT_W               = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               sw_rst,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic [STATE_W-1:0] state,
    output logic [FAIL_W-1:0]  fail_count
);

    // Terminal counts: each timed state exits on the cycle its counter hits these.
    localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SYS_LAST     = CNT_W'(SYS_RST_CYCLES - 1);

    logic              lock_s;
    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [FAIL_W-1:0] fail_d;
    logic              pll_rst_d;
    logic              sys_rst_d;
    logic              ready_d;

    // Bring LOCKED into the clk domain; every decision below uses lock_s.
    artemis_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // State, counter, failure count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PLL_RST;
            cnt_q      <= '0;
            fail_count <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fail_count <= fail_d;
            pll_rst    <= pll_rst_d;
            sys_rst    <= sys_rst_d;
            ready      <= ready_d;
        end
    end

    // Next state, counter and failure count; sw_rst overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_count;

        if (sw_rst) begin
            state_d = ST_PLL_RST;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_LOCK_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                        fail_d  = sat_inc(fail_count);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_LOCK_STABLE: begin
                    // A dropout here is treated as lock not yet settled, not a failure.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_SYS_RST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SYS_RST_HOLD: begin
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                        fail_d  = sat_inc(fail_count);
                    end else if (cnt_q == SYS_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PLL_RST;
                        cnt_d   = '0;
                        fail_d  = sat_inc(fail_count);
                    end
                end
                default: begin
                    state_d = ST_PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs follow the state being entered so they register alongside it.
        pll_rst_d = (state_d == ST_PLL_RST);
        sys_rst_d = (state_d != ST_RUN);
        ready_d   = (state_d == ST_RUN);
    end

    assign state = state_q;

endmodule
